// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// for R-type, lw, sw, beq, j and addi, stalling on the memory ready handshake.
module multicycle_control (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic       illegal_op,
   output logic [3:0] state
);

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      ALUWB  = 4'd7,
      BRANCH = 4'd8,
      JUMP   = 4'd9,
      ADDIEX = 4'd10,
      ADDIWB = 4'd11
   } state_e;

   typedef struct packed {
      logic       fetch;
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_write;
      logic       reg_dst;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctl_t;

   function automatic ctl_t state_ctl(input state_e s);
      ctl_t c;
      c = '0;
      case (s)
         FETCH: begin
            c.fetch     = 1'b1;
            c.mem_read  = 1'b1;
            c.alu_src_b = 2'b01;
         end
         DECODE: c.alu_src_b = 2'b11;
         MEMADR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
         end
         MEMRD: begin
            c.mem_read = 1'b1;
            c.i_or_d   = 1'b1;
         end
         MEMWB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         MEMWR: begin
            c.mem_write = 1'b1;
            c.i_or_d    = 1'b1;
         end
         EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = 2'b10;
         end
         ALUWB: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
         end
         BRANCH: begin
            c.alu_src_a     = 1'b1;
            c.alu_op        = 2'b01;
            c.pc_write_cond = 1'b1;
            c.pc_source     = 2'b01;
         end
         JUMP: begin
            c.pc_write  = 1'b1;
            c.pc_source = 2'b10;
         end
         ADDIEX: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
         end
         ADDIWB: c.reg_write = 1'b1;
         default: ;
      endcase
      return c;
   endfunction

   state_e state_q, state_d;
   ctl_t   ctl_q, ctl_d;
   logic   illegal;

   // ctl_q.fetch stays low through reset and the cycle after release, so the
   // first real FETCH cycle (and any IRWrite/PCWrite) begins on the first edge.
   always_comb begin
      state_d = FETCH;
      illegal = 1'b0;
      case (state_q)
         FETCH:  state_d = (ctl_q.fetch && mem_ready) ? DECODE : FETCH;
         DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_R:         state_d = EXEC;
               OP_BEQ:       state_d = BRANCH;
               OP_J:         state_d = JUMP;
               OP_ADDI:      state_d = ADDIEX;
               default:      illegal = 1'b1;
            endcase
         end
         MEMADR: state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
         MEMRD:  state_d = mem_ready ? MEMWB : MEMRD;
         MEMWR:  state_d = mem_ready ? FETCH : MEMWR;
         EXEC:   state_d = ALUWB;
         ADDIEX: state_d = ADDIWB;
         default: state_d = FETCH;
      endcase
      ctl_d = state_ctl(state_d);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= FETCH;
         ctl_q   <= '0;
      end else begin
         state_q <= state_d;
         ctl_q   <= ctl_d;
      end
   end

   assign IRWrite     = ctl_q.fetch & mem_ready;
   assign PCWrite     = ctl_q.pc_write | (ctl_q.fetch & mem_ready);
   assign PCWriteCond = ctl_q.pc_write_cond;
   assign IorD        = ctl_q.i_or_d;
   assign MemRead     = ctl_q.mem_read;
   assign MemWrite    = ctl_q.mem_write;
   assign MemtoReg    = ctl_q.mem_to_reg;
   assign RegWrite    = ctl_q.reg_write;
   assign RegDst      = ctl_q.reg_dst;
   assign ALUSrcA     = ctl_q.alu_src_a;
   assign ALUSrcB     = ctl_q.alu_src_b;
   assign ALUOp       = ctl_q.alu_op;
   assign PCSource    = ctl_q.pc_source;
   assign illegal_op  = illegal;
   assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-instruction cycle sequences are
// generated from the instruction timing rules and checked by a separate monitor.
module tb_multicycle_control;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, RegWrite, RegDst, ALUSrcA, illegal_op;
   logic [1:0] ALUSrcB, ALUOp, PCSource;
   logic [3:0] state;

   multicycle_control dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .MemtoReg(MemtoReg), .RegWrite(RegWrite), .RegDst(RegDst),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .PCSource(PCSource), .illegal_op(illegal_op), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [20:0] v;
      string       name;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned vectors = 0;
   int unsigned errors  = 0;
   logic [5:0]  cur_op  = 6'b0;

   // Output vector: strobes, selects, illegal_op, state.
   function automatic logic [20:0] expv(input logic [3:0] s, input logic mr, input logic ill);
      logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rd, asa;
      logic [1:0] asb, aop, pcs;
      {pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rd, asa} = '0;
      asb = 2'b00; aop = 2'b00; pcs = 2'b00;
      case (s)
         4'd0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
         4'd1:  asb = 2'b11;
         4'd2:  begin asa = 1; asb = 2'b10; end
         4'd3:  begin mrd = 1; iord = 1; end
         4'd4:  begin rw = 1; m2r = 1; end
         4'd5:  begin mwr = 1; iord = 1; end
         4'd6:  begin asa = 1; aop = 2'b10; end
         4'd7:  begin rw = 1; rd = 1; end
         4'd8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
         4'd9:  begin pcw = 1; pcs = 2'b10; end
         4'd10: begin asa = 1; asb = 2'b10; end
         4'd11: rw = 1;
         default: ;
      endcase
      return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rd, asa, asb, aop, pcs, ill, s};
   endfunction

   // Called just after a rising edge: drives one cycle and records its expectation.
   task automatic cycle(input logic rst, input logic [5:0] op, input logic mr,
                        input logic [20:0] e, input string name);
      exp_t x;
      reset = rst; opcode = op; mem_ready = mr;
      x.v = e; x.name = name;
      exp_q.push_back(x);
      @(posedge clk); #1;
   endtask

   task automatic do_reset(input int unsigned n, input string name);
      for (int unsigned i = 0; i < n; i++)
         cycle(1'b1, cur_op, 1'($urandom), 21'd0, name);
      cycle(1'b0, cur_op, 1'($urandom), 21'd0, name);
   endtask

   task automatic run_instr(input logic [5:0] op, input int unsigned wf,
                            input int unsigned wm, input string name);
      logic [3:0] body[$];
      logic       legal;
      legal = 1'b1;
      case (op)
         OP_R:    body = '{4'd6, 4'd7};
         OP_LW:   body = '{4'd2, 4'd3, 4'd4};
         OP_SW:   body = '{4'd2, 4'd5};
         OP_BEQ:  body = '{4'd8};
         OP_J:    body = '{4'd9};
         OP_ADDI: body = '{4'd10, 4'd11};
         default: legal = 1'b0;
      endcase
      for (int unsigned i = 0; i < wf; i++)
         cycle(1'b0, cur_op, 1'b0, expv(4'd0, 1'b0, 1'b0), name);
      cycle(1'b0, cur_op, 1'b1, expv(4'd0, 1'b1, 1'b0), name);
      cur_op = op;
      cycle(1'b0, op, 1'($urandom), expv(4'd1, 1'b0, !legal), name);
      foreach (body[k]) begin
         if (body[k] == 4'd3 || body[k] == 4'd5) begin
            for (int unsigned i = 0; i < wm; i++)
               cycle(1'b0, op, 1'b0, expv(body[k], 1'b0, 1'b0), name);
            cycle(1'b0, op, 1'b1, expv(body[k], 1'b1, 1'b0), name);
         end else begin
            cycle(1'b0, op, 1'($urandom), expv(body[k], 1'b0, 1'b0), name);
         end
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t        x;
         logic [20:0] got;
         x   = exp_q.pop_front();
         got = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op, state};
         vectors++;
         if (got !== x.v) begin
            errors++;
            $display("FAIL %s @%0t: got %06h (state %0d) expected %06h (state %0d)",
                     x.name, $time, got, got[3:0], x.v, x.v[3:0]);
         end
      end
   end

   initial begin
      logic [5:0] ops[6];
      logic [5:0] op;
      ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
      reset = 1'b1; opcode = 6'b0; mem_ready = 1'b1;
      @(posedge clk); #1;
      do_reset(2, "reset");

      run_instr(OP_R,    0, 0, "rtype");
      run_instr(OP_LW,   2, 1, "lw_wait");
      run_instr(OP_SW,   0, 0, "sw");
      run_instr(OP_BEQ,  0, 0, "beq");
      run_instr(OP_J,    0, 0, "j");
      run_instr(OP_ADDI, 0, 0, "addi");
      run_instr(6'h3F,   0, 0, "illegal");
      run_instr(OP_LW,   0, 0, "lw");

      // lw aborted by reset while stalled in MEMRD
      cycle(1'b0, cur_op, 1'b1, expv(4'd0, 1'b1, 1'b0), "abort");
      cur_op = OP_LW;
      cycle(1'b0, OP_LW, 1'b1, expv(4'd1, 1'b0, 1'b0), "abort");
      cycle(1'b0, OP_LW, 1'b1, expv(4'd2, 1'b0, 1'b0), "abort");
      cycle(1'b0, OP_LW, 1'b0, expv(4'd3, 1'b0, 1'b0), "abort");
      do_reset(1, "abort_reset");
      run_instr(OP_SW,   1, 2, "sw_after_reset");

      for (int unsigned n = 0; n < 250; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            do begin
               op = 6'($urandom);
            end while (op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI});
         end else begin
            op = ops[$urandom_range(0, 5)];
         end
         run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), "random");
      end

      @(posedge clk); #1;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

- Moore/Mealy finite-state controller that sequences the multicycle MIPS datapath.
- Drives every datapath select and strobe, including `RegDst`, which steers the 5-bit write-register mux (rt vs rd) in front of the register file.
- Sits between the instruction register opcode field and the datapath, and stalls on a memory ready handshake.
- Supports R-type, lw, sw, beq, j and addi. Any other opcode is flagged and skipped.

## Interface
- No parameters. Opcodes are fixed: R=6'b000000, lw=6'b100011, sw=6'b101011, beq=6'b000100, j=6'b000010, addi=6'b001000.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; forces state to FETCH.
- `opcode` in 6: IR[31:26]; valid from the DECODE cycle onward.
- `mem_ready` in 1: memory completes the current read/write this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemtoReg`, `RegWrite`, `RegDst`, `ALUSrcA` out 1: datapath strobes/selects. `RegDst` 0=rt, 1=rd.
- `ALUSrcB` out 2: 00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- `ALUOp` out 2: 00=add, 01=sub, 10=funct-decoded.
- `PCSource` out 2: 00=ALU result, 01=ALUOut, 10=jump target.
- `illegal_op` out 1: one-cycle pulse on an unsupported opcode.
- `state` out 4: current state encoding, for debug.

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11. Codes 12–15 are unreachable; if entered, next state is FETCH.
- Every output defaults to 0. Only the listed signals are asserted in each state.
- FETCH: MemRead=1, ALUSrcB=01.
  - IRWrite and PCWrite equal `mem_ready` (Mealy).
  - Stays in FETCH while `mem_ready`=0; goes to DECODE when it is 1.
- DECODE: ALUSrcB=11. Next state by opcode:
  - lw/sw → MEMADR; R → EXEC; beq → BRANCH; j → JUMP; addi → ADDIEX.
  - Any other opcode → FETCH, with `illegal_op`=1 for this cycle.
- MEMADR: ALUSrcA=1, ALUSrcB=10. Next is MEMRD if opcode=lw, else MEMWR.
- MEMRD: MemRead=1, IorD=1. Holds until `mem_ready`=1, then goes to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next is FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds until `mem_ready`=1, then goes to FETCH.
- EXEC: ALUSrcA=1, ALUOp=10. Next is ALUWB.
- ALUWB: RegWrite=1, RegDst=1. Next is FETCH.
- BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01. Next is FETCH.
- JUMP: PCWrite=1, PCSource=10. Next is FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10. Next is ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0. Next is FETCH.
- RegWrite is asserted only in MEMWB, ALUWB and ADDIWB. At most one memory strobe (MemRead or MemWrite) is high in any cycle.

## Timing
- While `reset`=1: state=0 and every output, including the Mealy strobes, is 0.
- The first FETCH cycle is the first rising edge after `reset` falls.
- Reset asserted mid-instruction aborts it immediately. No partial write strobe may appear after reset asserts.
- Cycles per instruction with `mem_ready` tied to 1:
  - beq = 3, j = 3.
  - R = 4, sw = 4, addi = 4.
  - lw = 5.
  - Illegal opcode = 2.
- Each cycle `mem_ready` is low in FETCH, MEMRD or MEMWR adds exactly one cycle. During a stall, outputs hold their state values with IRWrite=PCWrite=0.
- `mem_ready` is ignored outside FETCH, MEMRD and MEMWR.
- `opcode` is sampled in DECODE and MEMADR only. It must stay stable until the next FETCH completes.

## Test plan
- Reset: assert `reset` mid-MEMRD of a lw → `state`=0 and all outputs 0 in the same cycle. After release, FETCH with MemRead=1.
- R-type, `mem_ready`=1: state sequence 0,1,6,7,0. RegDst=1 and RegWrite=1 only in state 7; ALUOp=10 in state 6.
- lw with 2 wait cycles in FETCH and 1 in MEMRD (`mem_ready`=0):
  - State sequence 0,0,0,1,2,3,3,4,0.
  - IRWrite pulses once, on the last FETCH cycle.
  - In state 4, RegDst=0, MemtoReg=1 and RegWrite=1.
- sw then beq then j:
  - sw: states 0,1,2,5,0 with MemWrite=1 only in 5.
  - beq: states 0,1,8 with PCWriteCond=1 and PCSource=01.
  - j: states 0,1,9 with PCWrite=1 and PCSource=10.
- addi: states 0,1,10,11,0 with ALUSrcB=10 in 10, and RegDst=0, RegWrite=1 in 11.
- Illegal opcode 6'b111111: states 0,1,0. `illegal_op`=1 for exactly the DECODE cycle; RegWrite, MemWrite and PCWrite stay 0 after FETCH.
